// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer: entry layout and command codes.
package rob_pkg;

    localparam int ROB_ENTRY_W = 78;

    // Command types carried in entry bits [77:75]
    localparam logic [2:0] CMD_ALU_LD   = 3'd0;
    localparam logic [2:0] CMD_ST       = 3'd1;
    localparam logic [2:0] CMD_BCOND_NT = 3'd2;
    localparam logic [2:0] CMD_BCOND_T  = 3'd3;
    localparam logic [2:0] CMD_CBZ_NT   = 3'd4;
    localparam logic [2:0] CMD_CBZ_T    = 3'd5;
    localparam logic [2:0] CMD_BR       = 3'd6;
    localparam logic [2:0] CMD_BL       = 3'd7;

    // Entry layout, MSB first: cmd 77:75, rd 74:70, flag_valid 69,
    // flags 68:65 ({C,V,Z,N}), data_valid 64, data 63:0
    typedef struct packed {
        logic [2:0]  cmd;
        logic [4:0]  rd;
        logic        flag_valid;
        logic [3:0]  flags;
        logic        data_valid;
        logic [63:0] data;
    } rob_entry_t;

    // Fresh entry written at dispatch; flags are cleared too so a reused
    // slot never shows the previous occupant's flags on the commit word.
    function automatic rob_entry_t rob_alloc_entry(input logic [2:0] cmd,
                                                   input logic [4:0] rd);
        rob_entry_t e;
        e.cmd        = cmd;
        e.rd         = rd;
        e.flag_valid = 1'b0;
        e.flags      = 4'b0000;
        e.data_valid = 1'b0;
        e.data       = 64'd0;
        return e;
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer register, modulo SIZE (SIZE need not be a power of two).
module rob_ptr #(
    parameter int SIZE = 32,
    parameter int W    = $clog2(SIZE)
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    localparam logic [W-1:0] LAST = W'(SIZE - 1);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer: clear dominates, otherwise increment with wrap at SIZE-1
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            if (ptr_q == LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order writeback,
// in-order retire from the head, operand bypass reads and full flush.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int addrSize   = $clog2(ROBsize)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  alloc_valid_i,
    input  logic [2:0]            alloc_cmd_i,
    input  logic [4:0]            alloc_rd_i,
    output logic                  alloc_ready_o,
    output logic [addrSize-1:0]   alloc_tag_o,
    input  logic                  wb_valid_i,
    input  logic [addrSize-1:0]   wb_tag_i,
    input  logic [63:0]           wb_data_i,
    input  logic                  wb_flagValid_i,
    input  logic [3:0]            wb_flags_i,
    input  logic [addrSize-1:0]   rdA_tag_i,
    input  logic [addrSize-1:0]   rdB_tag_i,
    output logic                  rdA_valid_o,
    output logic                  rdB_valid_o,
    output logic [63:0]           rdA_data_o,
    output logic [63:0]           rdB_data_o,
    output logic [addrSize-1:0]   ROBhead_o,
    output logic [77:0]           ROBcommitReadData_o,
    input  logic                  ROBupdateHead_i,
    input  logic                  flush_i,
    output logic [ROBsizeLog-1:0] count_o,
    output logic                  empty_o
);

    localparam logic [ROBsizeLog-1:0] FULL_CNT = ROBsizeLog'(ROBsize);

    rob_entry_t            rob_q [ROBsize];
    rob_entry_t            rob_d [ROBsize];
    logic [ROBsize-1:0]    busy_q;
    logic [ROBsize-1:0]    busy_d;
    logic [ROBsizeLog-1:0] count_q;
    logic [ROBsizeLog-1:0] count_d;

    logic [addrSize-1:0]   head_s;
    logic [addrSize-1:0]   tail_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  alloc_ok_s;
    logic                  retire_ok_s;
    logic                  wb_ok_s;

    // Tags beyond ROBsize-1 exist when ROBsize is not a power of two
    function automatic logic tag_ok(input logic [addrSize-1:0] tag);
        return ({1'b0, tag} < (addrSize + 1)'(ROBsize));
    endfunction

    assign full_s      = (count_q == FULL_CNT);
    assign empty_s     = (count_q == '0);
    // Full is judged on registered state, so a same-cycle retire does not make room
    assign alloc_ok_s  = alloc_valid_i & ~full_s & ~flush_i;
    assign retire_ok_s = ROBupdateHead_i & ~empty_s & ~flush_i;
    assign wb_ok_s     = wb_valid_i & ~flush_i & tag_ok(wb_tag_i) &
                         (tag_ok(wb_tag_i) ? busy_q[wb_tag_i] : 1'b0);

    rob_ptr #(.SIZE(ROBsize), .W(addrSize)) u_head_ptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (flush_i),
        .inc_i   (retire_ok_s),
        .ptr_o   (head_s)
    );

    rob_ptr #(.SIZE(ROBsize), .W(addrSize)) u_tail_ptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (flush_i),
        .inc_i   (alloc_ok_s),
        .ptr_o   (tail_s)
    );

    // Next entry state: flush, else writeback, then allocate, then retire (retire wins on the head)
    always_comb begin
        rob_d   = rob_q;
        busy_d  = busy_q;
        count_d = count_q;
        if (flush_i) begin
            busy_d  = '0;
            count_d = '0;
            for (int i = 0; i < ROBsize; i++) begin
                rob_d[i].data_valid = 1'b0;
                rob_d[i].flag_valid = 1'b0;
            end
        end else begin
            if (wb_ok_s) begin
                rob_d[wb_tag_i].data       = wb_data_i;
                rob_d[wb_tag_i].data_valid = 1'b1;
                if (wb_flagValid_i) begin
                    rob_d[wb_tag_i].flags      = wb_flags_i;
                    rob_d[wb_tag_i].flag_valid = 1'b1;
                end else begin
                    rob_d[wb_tag_i].flags      = rob_q[wb_tag_i].flags;
                    rob_d[wb_tag_i].flag_valid = rob_q[wb_tag_i].flag_valid;
                end
            end else begin
                busy_d = busy_q;
            end

            if (alloc_ok_s) begin
                rob_d[tail_s]  = rob_alloc_entry(alloc_cmd_i, alloc_rd_i);
                busy_d[tail_s] = 1'b1;
            end else begin
                count_d = count_q;
            end

            if (retire_ok_s) begin
                busy_d[head_s]           = 1'b0;
                rob_d[head_s].data_valid = 1'b0;
                rob_d[head_s].flag_valid = 1'b0;
            end else begin
                count_d = count_q;
            end

            case ({alloc_ok_s, retire_ok_s})
                2'b10:   count_d = count_q + ROBsizeLog'(1);
                2'b01:   count_d = count_q - ROBsizeLog'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Entry storage, busy bits and occupancy with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            busy_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROBsize; i++) begin
                rob_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            for (int i = 0; i < ROBsize; i++) begin
                rob_q[i] <= rob_d[i];
            end
        end
    end

    assign alloc_ready_o       = ~full_s;
    assign alloc_tag_o         = tail_s;
    assign ROBhead_o           = head_s;
    assign count_o             = count_q;
    assign empty_o             = empty_s;
    // Zero word when empty so the commit stage sees data_valid = 0
    assign ROBcommitReadData_o = empty_s ? {ROB_ENTRY_W{1'b0}} : rob_q[head_s];

    // Operand bypass: no forwarding of same-cycle writeback
    assign rdA_valid_o = tag_ok(rdA_tag_i) ?
                         (busy_q[rdA_tag_i] & rob_q[rdA_tag_i].data_valid) : 1'b0;
    assign rdB_valid_o = tag_ok(rdB_tag_i) ?
                         (busy_q[rdB_tag_i] & rob_q[rdB_tag_i].data_valid) : 1'b0;
    assign rdA_data_o  = tag_ok(rdA_tag_i) ? rob_q[rdA_tag_i].data : 64'd0;
    assign rdB_data_o  = tag_ok(rdB_tag_i) ? rob_q[rdB_tag_i].data : 64'd0;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer that sits directly upstream of the commit stage.
- Entries are allocated in program order at dispatch and filled out of order by execution writeback.
- The head entry is presented every cycle as a 78-bit commit word, and is retired when the commit stage pulses the head-update strobe.
- Also supplies tag-indexed operand bypass reads to dispatch, and a full flush used on branch restore.

Parameters:
- ROBsize, 32, number of entries (any value >= 2, not required to be a power of two).
- ROBsizeLog, $clog2(ROBsize+1), width of the occupancy count.
- addrSize, $clog2(ROBsize), width of tags, head and tail pointers.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- alloc_valid_i  in  1  dispatch requests a new entry.
- alloc_cmd_i  in  3  command type, written to entry bits [77:75].
- alloc_rd_i  in  5  destination register or condition code, written to bits [74:70].
- alloc_ready_o  out  1  high when not full; allocation happens only when alloc_valid_i & alloc_ready_o.
- alloc_tag_o  out  addrSize  current tail index, i.e. the tag given to the allocating instruction.
- wb_valid_i  in  1  writeback strobe.
- wb_tag_i  in  addrSize  entry being written back.
- wb_data_i  in  64  result or branch target.
- wb_flagValid_i  in  1  writeback carries flags.
- wb_flags_i  in  4  flags {C,V,Z,N} in bits [3:0] = {carry, overflow, zero, negative}, stored to [68:65].
- rdA_tag_i, rdB_tag_i  in  addrSize  operand lookup tags.
- rdA_valid_o, rdB_valid_o  out  1  the addressed entry is occupied and its dataValid is set.
- rdA_data_o, rdB_data_o  out  64  data of the addressed entry.
- ROBhead_o  out  addrSize  head index.
- ROBcommitReadData_o  out  78  head entry, combinational.
- ROBupdateHead_i  in  1  retire the head entry.
- flush_i  in  1  discard all entries.
- count_o  out  ROBsizeLog  occupancy.
- empty_o  out  1  occupancy is zero.

Behaviour:
- **Storage.** Each entry holds {cmd[2:0], rd[4:0], flagValid, flags[3:0], dataValid, data[63:0]}, plus a per-entry busy bit.
- **Reset (reset_i low, async).**
  - head = tail = 0, count = 0, all busy/dataValid/flagValid = 0.
  - Outputs: alloc_ready_o = 1, alloc_tag_o = 0, ROBhead_o = 0, ROBcommitReadData_o = 0, empty_o = 1, count_o = 0, rd*_valid_o = 0.
- **Allocation.**
  - On a cycle where alloc_valid_i & ~full, at the clock edge: entry[tail] gets busy = 1, cmd/rd loaded, dataValid = flagValid = 0, data = 0.
  - tail advances by one; tail == ROBsize-1 wraps to 0.
  - full means count == ROBsize, taken from registered state. Allocation while full is refused and leaves no state change, even if a retire occurs in the same cycle.
- **Writeback.**
  - When wb_valid_i and entry[wb_tag_i] is busy: data = wb_data_i and dataValid = 1 at the next edge.
  - If wb_flagValid_i is also set: flags = wb_flags_i and flagValid = 1.
  - Writeback to a non-busy entry is ignored. This includes the entry being allocated in the same cycle.
- **Commit output.**
  - ROBcommitReadData_o = entry[head] when count != 0.
  - When empty it is all zeros, so dataValid (bit 64) = 0 and the commit stage never retires from an empty buffer.
- **Retire.**
  - ROBupdateHead_i with count != 0 clears busy/dataValid/flagValid of entry[head] and advances head with wrap.
  - ROBupdateHead_i while empty is ignored.
  - Retire and writeback to the head tag in the same cycle: the entry is cleared (retire wins).
- **Count update.**
  - Simultaneous accepted alloc and retire leaves count unchanged; both pointers advance.
  - Otherwise count is incremented or decremented by one.
- **Flush.**
  - flush_i has the highest priority.
  - At the edge: head = tail = 0, count = 0, all busy/valid bits cleared. Alloc, writeback and retire in that cycle are discarded.
- **Operand reads.** Combinational, with no forwarding of same-cycle writeback data. rd*_valid_o = busy & dataValid of the addressed entry.
- **Latency.** Allocation becomes visible at the head on the cycle after the edge; writeback becomes visible on the commit and read ports on the cycle after wb_valid_i.

Decomposition:
- **Shared package rob_pkg.** Holds:
  - the entry struct with field offsets 77:75, 74:70, 69, 68:65, 64, 63:0;
  - the ROB_ENTRY_W = 78 constant;
  - command-type constants 0-7: ALU/LD, ST, BCOND_NT, BCOND_T, CBZ_NT, CBZ_T, BR, BL.
- **Sub-module rob_ptr.** A wrapping pointer register (addrSize width, modulo ROBsize, increment and clear inputs), instantiated for both head and tail.

Test Plan (ROBsize=4):
- **Reset then fill.** Allocate 4 entries (cmd 0, rd 1..4). Expect tags 0,1,2,3, count_o = 4, alloc_ready_o = 0. A fifth alloc_valid_i is refused and tail stays at 0.
- **Out-of-order writeback.** Write back tag 2 (data 0x22), then tag 0 (data 0x10, flags 4'b0010). Expect ROBcommitReadData_o[64] = 1, [63:0] = 0x10 and [69] = 1 only after the tag 0 writeback. Expect rdA_tag_i = 2 to give valid = 1, data = 0x22.
- **Retire plus allocate while full.** Pulse ROBupdateHead_i together with alloc_valid_i while count = 4. Expect the alloc to be refused, count = 3, head = 1. On the next cycle the alloc is accepted with tag 0 and the tail wraps.
- **Wrap-around.** Perform 10 alloc/retire pairs. Expect head/tail sequence 0,1,2,3,0,..., count constant, and no stale dataValid on the reused entries.
- **Flush mid-operation.** With 3 busy entries, assert flush_i together with wb_valid_i and alloc_valid_i. Expect count = 0, empty_o = 1, head = tail = 0, commit word = 0, and the previously written tag reading valid = 0.
- **Async reset mid-operation.** Drop reset_i between clock edges with 2 entries present. Outputs return to their reset values immediately, without waiting for a clock edge.
